// File: rtl/hd_pkg.sv
// Shared encodings for the hardwired-controller timing slice: beats, phases, timing states.
package hd_pkg;

    localparam int unsigned BEAT_W  = 3;
    localparam int unsigned PHASE_W = 3;

    typedef logic [BEAT_W-1:0]  beat_t;
    typedef logic [PHASE_W-1:0] phase_t;

    localparam beat_t W_B1 = 3'b001;
    localparam beat_t W_B2 = 3'b010;
    localparam beat_t W_B3 = 3'b100;

    localparam phase_t PH_NONE = 3'b000;
    localparam phase_t PH_T1   = 3'b001;
    localparam phase_t PH_T2   = 3'b010;
    localparam phase_t PH_T3   = 3'b100;

    typedef enum logic [1:0] {
        TG_IDLE = 2'd0,
        TG_RUN  = 2'd1,
        TG_HALT = 2'd2
    } tg_state_e;

    // Beat taken at beat end; SHORT only matters in W1, LONG only in W2.
    function automatic beat_t next_beat(beat_t w, logic short_req, logic long_req);
        beat_t nb;
        nb = W_B1;
        case (w)
            W_B1:    nb = short_req ? W_B1 : W_B2;
            W_B2:    nb = long_req  ? W_B3 : W_B1;
            default: nb = W_B1;
        endcase
        return nb;
    endfunction

    function automatic phase_t next_phase(phase_t t);
        phase_t np;
        np = PH_T1;
        case (t)
            PH_T1:   np = PH_T2;
            PH_T2:   np = PH_T3;
            default: np = PH_T1;
        endcase
        return np;
    endfunction

endpackage

// File: rtl/hd_debounce.sv
// Start-button conditioner: 2-flop synchroniser, stability counter, rising-edge pulse.
module hd_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic CLK,
    input  logic RST,
    input  logic QD,
    output logic start_pulse
);

    localparam int unsigned DB_CNT_W = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic                sync1;
    logic                sync2;
    logic                level;
    logic                level_d;
    logic                pulse;
    logic [DB_CNT_W-1:0] cnt;

    // Level is only accepted once the synchronised input has differed for DEBOUNCE_CYCLES samples.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            level   <= 1'b0;
            level_d <= 1'b0;
            pulse   <= 1'b0;
            cnt     <= '0;
        end else begin
            sync1   <= QD;
            sync2   <= sync1;
            level_d <= level;
            pulse   <= level & ~level_d;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == DB_CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + DB_CNT_W'(1);
            end
        end
    end

    assign start_pulse = pulse;

endmodule

// File: rtl/hd_timing_gen.sv
// Beat/phase timing generator feeding the hardwired controller: W[3:1], T1..T3, beat count, CLR.
module hd_timing_gen
    import hd_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             QD,
    input  logic             SHORT,
    input  logic             LONG,
    input  logic             STOP,
    output logic             T1,
    output logic             T2,
    output logic             T3,
    output logic [2:0]       W,
    output logic             RUNNING,
    output logic             CLR,
    output logic [CNT_W-1:0] BEAT_CNT
);

    logic             start_pulse;

    tg_state_e        state_q;
    tg_state_e        state_d;
    phase_t           t_q;
    phase_t           t_d;
    beat_t            w_q;
    beat_t            w_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             run_q;
    logic             run_d;
    logic             clr_q;

    hd_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
        .CLK         (CLK),
        .RST         (RST),
        .QD          (QD),
        .start_pulse (start_pulse)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= TG_IDLE;
            t_q     <= PH_NONE;
            w_q     <= W_B1;
            cnt_q   <= '0;
            run_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            t_q     <= t_d;
            w_q     <= w_d;
            cnt_q   <= cnt_d;
            run_q   <= run_d;
            clr_q   <= 1'b1;
        end
    end

    // Next state, phase ring and beat sequencing; W/BEAT_CNT only move at T3.
    always_comb begin
        state_d = state_q;
        t_d     = t_q;
        w_d     = w_q;
        cnt_d   = cnt_q;

        case (state_q)
            TG_IDLE: begin
                w_d = W_B1;
                t_d = PH_NONE;
                if (start_pulse) begin
                    state_d = TG_RUN;
                    t_d     = PH_T1;
                end
            end
            TG_HALT: begin
                t_d = PH_NONE;
                if (start_pulse) begin
                    state_d = TG_RUN;
                    t_d     = PH_T1;
                end
            end
            TG_RUN: begin
                t_d = next_phase(t_q);
                if (t_q == PH_T3) begin
                    w_d   = next_beat(w_q, SHORT, LONG);
                    cnt_d = cnt_q + CNT_W'(1);
                    if (STOP) begin
                        state_d = TG_HALT;
                        t_d     = PH_NONE;
                    end
                end
            end
            default: begin
                state_d = TG_IDLE;
                t_d     = PH_NONE;
                w_d     = W_B1;
            end
        endcase

        run_d = (state_d == TG_RUN);
    end

    assign T1       = t_q[0];
    assign T2       = t_q[1];
    assign T3       = t_q[2];
    assign W        = w_q;
    assign RUNNING  = run_q;
    assign CLR      = clr_q;
    assign BEAT_CNT = cnt_q;

endmodule

// File: tb/tb_hd_timing_gen.sv
// Directed bench for hd_timing_gen with a queue of expected output snapshots.
module tb_hd_timing_gen;

    localparam int unsigned DEB = 4;
    localparam int unsigned CW  = 4;

    localparam logic [2:0] B1 = 3'b001;
    localparam logic [2:0] B2 = 3'b010;
    localparam logic [2:0] B3 = 3'b100;

    logic          CLK;
    logic          RST;
    logic          QD;
    logic          SHORT;
    logic          LONG;
    logic          STOP;
    logic          T1;
    logic          T2;
    logic          T3;
    logic [2:0]    W;
    logic          RUNNING;
    logic          CLR;
    logic [CW-1:0] BEAT_CNT;

    logic [11:0]   sb[$];
    int            n_cmp;
    int            n_bad;
    logic [2:0]    exp_w;
    logic [3:0]    exp_cnt;

    hd_timing_gen #(
        .DEBOUNCE_CYCLES (DEB),
        .CNT_W           (CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .QD       (QD),
        .SHORT    (SHORT),
        .LONG     (LONG),
        .STOP     (STOP),
        .T1       (T1),
        .T2       (T2),
        .T3       (T3),
        .W        (W),
        .RUNNING  (RUNNING),
        .CLR      (CLR),
        .BEAT_CNT (BEAT_CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Snapshot layout: {W, T3 T2 T1, RUNNING, CLR, BEAT_CNT}
    function automatic logic [11:0] mk(logic [2:0] w, logic [2:0] t, logic r, logic c, logic [3:0] n);
        return {w, t, r, c, n};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag);
        logic [11:0] exp;
        logic [11:0] obs;
        n_cmp++;
        if (sb.size() == 0) begin
            n_bad++;
            $error("FAIL %s: no expected entry queued", tag);
        end else begin
            exp = sb.pop_front();
            obs = {W, T3, T2, T1, RUNNING, CLR, BEAT_CNT};
            assert (obs === exp) else begin
                n_bad++;
                $error("FAIL %s: observed W=%b T=%b RUN=%b CLR=%b CNT=%0d, expected W=%b T=%b RUN=%b CLR=%b CNT=%0d",
                       tag, obs[11:9], obs[8:6], obs[5], obs[4], obs[3:0],
                       exp[11:9], exp[8:6], exp[5], exp[4], exp[3:0]);
            end
        end
    endtask

    // Stopped (idle or halted) for n cycles: no phases, W and count frozen.
    task automatic idle_for(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            sb.push_back(mk(exp_w, 3'b000, 1'b0, 1'b1, exp_cnt));
            tick();
            check(tag);
        end
    endtask

    // One beat starting at its visible T1; nxt is the beat expected afterwards.
    task automatic run_beat(input string tag, input logic s, input logic l, input logic p,
                            input logic [2:0] nxt);
        SHORT = s;
        LONG  = l;
        STOP  = p;
        for (int i = 0; i < 3; i++)
            sb.push_back(mk(exp_w, 3'(1 << i), 1'b1, 1'b1, exp_cnt));
        for (int i = 0; i < 3; i++) begin
            check(tag);
            tick();
        end
        SHORT   = 1'b0;
        LONG    = 1'b0;
        STOP    = 1'b0;
        exp_w   = nxt;
        exp_cnt = exp_cnt + 4'd1;
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        RST     = 1'b1;
        QD      = 1'b0;
        SHORT   = 1'b0;
        LONG    = 1'b0;
        STOP    = 1'b0;
        exp_w   = B1;
        exp_cnt = 4'd0;

        // Reset and CLR release
        tick();
        tick();
        sb.push_back(mk(B1, 3'b000, 1'b0, 1'b0, 4'd0));
        check("reset_state");
        RST = 1'b0;
        tick();
        sb.push_back(mk(B1, 3'b000, 1'b0, 1'b1, 4'd0));
        check("clr_release");

        // Short glitches must not start the machine
        for (int g = 0; g < 3; g++) begin
            QD = 1'b1;
            idle_for("glitch_high", 3);
            QD = 1'b0;
            idle_for("glitch_gap", 6);
        end

        // Clean press: T1 appears on the 8th edge after QD rises
        QD = 1'b1;
        idle_for("press_latency", 7);
        tick();
        run_beat("seq_b0", 1'b0, 1'b0, 1'b0, B2);
        run_beat("seq_b1", 1'b0, 1'b0, 1'b0, B1);
        run_beat("seq_b2", 1'b0, 1'b0, 1'b0, B2);
        run_beat("seq_b3", 1'b0, 1'b0, 1'b0, B1);
        QD = 1'b0;

        // SHORT / LONG handling
        run_beat("short_in_w1", 1'b1, 1'b0, 1'b0, B1);
        run_beat("long_in_w1",  1'b0, 1'b1, 1'b0, B2);
        run_beat("long_in_w2",  1'b0, 1'b1, 1'b0, B3);
        run_beat("both_in_w3",  1'b1, 1'b1, 1'b0, B1);
        run_beat("plain_w1",    1'b0, 1'b0, 1'b0, B2);
        run_beat("short_in_w2", 1'b1, 1'b0, 1'b0, B1);

        // STOP, halt, resume on a fresh press
        run_beat("stop_w1", 1'b0, 1'b0, 1'b1, B2);
        idle_for("halt_hold", 5);
        QD = 1'b1;
        idle_for("resume_wait", 7);
        tick();
        run_beat("resume_w2_long_stop", 1'b0, 1'b1, 1'b1, B3);
        idle_for("held_no_repulse", 10);
        QD = 1'b0;
        idle_for("released_halt", 10);
        QD = 1'b1;
        idle_for("repress_wait", 7);
        tick();
        run_beat("resume_w3", 1'b0, 1'b0, 1'b0, B1);
        QD = 1'b0;
        run_beat("after_w3", 1'b0, 1'b0, 1'b0, B2);

        // Reset in W2/T2 with STOP pending
        sb.push_back(mk(B2, 3'b001, 1'b1, 1'b1, exp_cnt));
        check("pre_rst_t1");
        tick();
        sb.push_back(mk(B2, 3'b010, 1'b1, 1'b1, exp_cnt));
        check("pre_rst_t2");
        STOP = 1'b1;
        RST  = 1'b1;
        tick();
        sb.push_back(mk(B1, 3'b000, 1'b0, 1'b0, 4'd0));
        check("rst_mid_beat");
        RST     = 1'b0;
        STOP    = 1'b0;
        exp_w   = B1;
        exp_cnt = 4'd0;
        tick();
        sb.push_back(mk(B1, 3'b000, 1'b0, 1'b1, 4'd0));
        check("rst_release");
        idle_for("rst_no_resume", 4);

        // Counter wraps after 16 beats with CNT_W=4
        QD = 1'b1;
        idle_for("wrap_press", 7);
        tick();
        for (int b = 0; b < 16; b++) begin
            run_beat("wrap_beat", 1'b1, 1'b0, 1'b0, B1);
            if (b == 0) QD = 1'b0;
        end
        run_beat("wrap_zero_stop", 1'b0, 1'b0, 1'b1, B2);
        idle_for("wrap_halt", 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
